// File: rtl/i2s_tx_framer.sv
// Stereo I2S transmitter: one-pair input buffer, bclk/lrclk generation, MSB-first serialiser.
// Optional build macro I2S_TX_HOLD_LAST_EN: repeat the last sample pair on underrun instead of silence.
`timescale 1ns/1ps
module i2s_tx_framer #(
  parameter int WIDTH    = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sd,
  output logic             frame_start,
  output logic             underrun
);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [DW-1:0]    r_div_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_bclk, r_lrclk, r_sd, r_frame_start, r_underrun;
  logic [WIDTH-1:0] r_shreg, r_right_hold;
  logic             r_buf_full;
  logic [WIDTH-1:0] r_left_buf, r_right_buf;

  logic             w_accept, w_tick, w_fall, w_slot_end, w_frame_load;
  logic [WIDTH-1:0] w_uf_left, w_uf_right;

  assign in_ready    = !r_buf_full;
  assign bclk        = r_bclk;
  assign lrclk       = r_lrclk;
  assign sd          = r_sd;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

  assign w_accept     = in_valid && !r_buf_full;
  assign w_tick       = (r_div_cnt == DIV_LAST);
  // bclk is only ever high while running, so this is the registered 1->0 edge
  assign w_fall       = enable && (r_state == S_RUN) && w_tick && r_bclk;
  assign w_slot_end   = w_fall && (r_bit_cnt == BIT_LAST);
  assign w_frame_load = w_slot_end && r_lrclk;

`ifdef I2S_TX_HOLD_LAST_EN
  logic [WIDTH-1:0] r_last_left;
  assign w_uf_left  = r_last_left;
  assign w_uf_right = r_right_hold;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           r_last_left <= '0;
    else if (w_frame_load && r_buf_full) r_last_left <= r_left_buf;
  end
`else
  assign w_uf_left  = '0;
  assign w_uf_right = '0;
`endif

  // The buffer is only drained by a frame load; an accept never coincides with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf_full  <= 1'b0;
      r_left_buf  <= '0;
      r_right_buf <= '0;
    end else if (w_frame_load && r_buf_full) begin
      r_buf_full  <= 1'b0;
    end else if (w_accept) begin
      r_buf_full  <= 1'b1;
      r_left_buf  <= left_in;
      r_right_buf <= right_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_div_cnt     <= '0;
      r_bit_cnt     <= BIT_LAST;
      r_bclk        <= 1'b0;
      r_lrclk       <= 1'b1;
      r_sd          <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_shreg       <= '0;
      r_right_hold  <= '0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      if (!enable) begin
        r_state   <= S_IDLE;
        r_div_cnt <= '0;
        r_bit_cnt <= BIT_LAST;
        r_bclk    <= 1'b0;
        r_lrclk   <= 1'b1;
        r_sd      <= 1'b0;
        r_shreg   <= '0;
      end else begin
        r_state <= S_RUN;
        if (w_tick) begin
          r_div_cnt <= '0;
          r_bclk    <= ~r_bclk;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
        if (w_fall) begin
          r_sd      <= r_shreg[WIDTH-1];
          r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_slot_end) begin
            r_bit_cnt     <= '0;
            r_lrclk       <= ~r_lrclk;
            r_frame_start <= r_lrclk;
            if (!r_lrclk) begin
              r_shreg <= r_right_hold;
            end else if (r_buf_full) begin
              r_shreg      <= r_left_buf;
              r_right_hold <= r_right_buf;
            end else begin
              r_shreg      <= w_uf_left;
              r_right_hold <= w_uf_right;
              r_underrun   <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule
